// File: rtl/mips_main_if.sv
// rtl/mips_main_if.sv - data-memory write bus observed from outside the computer
interface mips_main_if;
    logic [31:0] writedata;
    logic [31:0] dataadr;
    logic        memwrite;

    modport master (output writedata, output dataadr, output memwrite);
    modport slave  (input  writedata, input  dataadr, input  memwrite);
endinterface

// File: rtl/mips_main.sv
// rtl/mips_main.sv - single-cycle MIPS subset computer with instruction ROM and data RAM
module mips_main #(
    parameter int    IMEM_DEPTH = 64,
    parameter int    DMEM_DEPTH = 64,
    parameter string IMEM_FILE  = "memfile.dat"
) (
    input  logic        clk,
    input  logic        reset,
    mips_main_if.master bus
);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_t;

    // The ROM powers up holding the standard memfile.dat program; other names leave it blank.
    localparam logic [31:0] IMG_MASK = (IMEM_FILE == "memfile.dat") ? 32'hffff_ffff : 32'h0;

    logic [31:0] imem [IMEM_DEPTH] = '{
        0:  32'h20020005 & IMG_MASK,  1:  32'h2003000c & IMG_MASK,
        2:  32'h2067fff7 & IMG_MASK,  3:  32'h00e22025 & IMG_MASK,
        4:  32'h00642824 & IMG_MASK,  5:  32'h00a42820 & IMG_MASK,
        6:  32'h10a7000a & IMG_MASK,  7:  32'h0064202a & IMG_MASK,
        8:  32'h10800001 & IMG_MASK,  9:  32'h20050000 & IMG_MASK,
        10: 32'h00e2202a & IMG_MASK,  11: 32'h00853820 & IMG_MASK,
        12: 32'h00e23822 & IMG_MASK,  13: 32'hac670044 & IMG_MASK,
        14: 32'h8c020050 & IMG_MASK,  15: 32'h08000011 & IMG_MASK,
        16: 32'h20020001 & IMG_MASK,  17: 32'hac020054 & IMG_MASK,
        default: 32'h0
    };
    logic [31:0] dmem [DMEM_DEPTH];
    logic [31:0] rf   [32];

    logic [31:0] pc, pcplus4, pcbranch, pcnext, instr, signimm;
    logic [31:0] srca, srcb, rd2, aluresult, readdata, result;
    logic [4:0]  wa;
    logic        regwrite, regdst, alusrc, memtoreg, mw, branch, jump, zero, memwrite;
    alu_t        aluctl;

    assign instr   = imem[pc[7:2]];
    assign signimm = {{16{instr[15]}}, instr[15:0]};

    always_comb begin
        regwrite = 1'b0;
        regdst   = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        mw       = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        aluctl   = ALU_ADD;
        case (instr[31:26])
            6'b000000: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                case (instr[5:0])
                    6'b100000: aluctl = ALU_ADD;
                    6'b100010: aluctl = ALU_SUB;
                    6'b100100: aluctl = ALU_AND;
                    6'b100101: aluctl = ALU_OR;
                    6'b101010: aluctl = ALU_SLT;
                    default:   regwrite = 1'b0;
                endcase
            end
            6'b100011: begin regwrite = 1'b1; alusrc = 1'b1; memtoreg = 1'b1; end
            6'b101011: begin alusrc = 1'b1; mw = 1'b1; end
            6'b000100: begin branch = 1'b1; aluctl = ALU_SUB; end
            6'b001000: begin regwrite = 1'b1; alusrc = 1'b1; end
            6'b000010: jump = 1'b1;
            default: ;
        endcase
    end

    assign srca = (instr[25:21] == 5'd0) ? 32'd0 : rf[instr[25:21]];
    assign rd2  = (instr[20:16] == 5'd0) ? 32'd0 : rf[instr[20:16]];
    assign srcb = alusrc ? signimm : rd2;

    always_comb begin
        case (aluctl)
            ALU_SUB: aluresult = srca - srcb;
            ALU_AND: aluresult = srca & srcb;
            ALU_OR:  aluresult = srca | srcb;
            ALU_SLT: aluresult = {31'd0, $signed(srca) < $signed(srcb)};
            default: aluresult = srca + srcb;
        endcase
    end

    assign zero     = (aluresult == 32'd0);
    assign pcplus4  = pc + 32'd4;
    assign pcbranch = pcplus4 + {signimm[29:0], 2'b00};
    assign pcnext   = jump              ? {pcplus4[31:28], instr[25:0], 2'b00} :
                      (branch && zero)  ? pcbranch : pcplus4;

    // Reset blocks every architectural write so a mid-program restart keeps RAM and registers.
    assign memwrite = mw & reset;
    assign readdata = dmem[aluresult[7:2]];
    assign result   = memtoreg ? readdata : aluresult;
    assign wa       = regdst ? instr[15:11] : instr[20:16];

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= 32'd0;
        end else begin
            pc <= pcnext;
            if (regwrite && (wa != 5'd0))
                rf[wa] <= result;
        end
    end

    always_ff @(posedge clk) begin
        if (memwrite)
            dmem[aluresult[7:2]] <= rd2;
    end

    assign bus.writedata = rd2;
    assign bus.dataadr   = aluresult;
    assign bus.memwrite  = memwrite;
endmodule

// File: tb/tb_mips_main.sv
// tb/tb_mips_main.sv - directed program tests for mips_main, checked through store traffic
module tb_mips_main;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] prog   [$];
    logic [31:0] st_adr [$];
    logic [31:0] st_dat [$];

    mips_main_if bus();
    mips_main dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q [$], input int i);
        return (i < q.size()) ? q[i] : 32'hdead_beef;
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 64; i++)
            dut.imem[i] = (i < prog.size()) ? prog[i] : 32'h0;
    endtask

    // one reset edge with the current prog loaded, then release at the negedge
    task automatic restart();
        reset = 1'b0;
        load_prog();
        st_adr.delete();
        st_dat.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            if (bus.memwrite === 1'b1) begin
                st_adr.push_back(bus.dataadr);
                st_dat.push_back(bus.writedata);
            end else if (bus.memwrite !== 1'b0) begin
                check_eq("memwrite_known", {31'd0, bus.memwrite}, 32'd0);
            end
            @(negedge clk);
        end
    endtask

    task automatic set_std();
        prog = '{32'h20020005, 32'h2003000c, 32'h2067fff7, 32'h00e22025,
                 32'h00642824, 32'h00a42820, 32'h10a7000a, 32'h0064202a,
                 32'h10800001, 32'h20050000, 32'h00e2202a, 32'h00853820,
                 32'h00e23822, 32'hac670044, 32'h8c020050, 32'h08000011,
                 32'h20020001, 32'hac020054};
    endtask

    initial begin
        // 1: held in reset, built-in image; instr 0 is addi $2,$0,5 so dataadr=5
        repeat (2) begin
            @(negedge clk);
            check_eq("t1_memwrite", {31'd0, bus.memwrite}, 32'd0);
            check_eq("t1_dataadr",  bus.dataadr, 32'd5);
        end

        // 2: standard program from the power-up image
        reset = 1'b1;
        run(25);
        check_eq("t2_count", st_adr.size(), 32'd2);
        check_eq("t2_adr0",  at(st_adr, 0), 32'd80);
        check_eq("t2_dat0",  at(st_dat, 0), 32'd7);
        check_eq("t2_adr1",  at(st_adr, 1), 32'd84);
        check_eq("t2_dat1",  at(st_dat, 1), 32'd7);

        // 3: writes to $0 are discarded
        prog = '{32'h20000005, 32'hac000000};
        restart();
        run(4);
        check_eq("t3_count", st_adr.size(), 32'd1);
        check_eq("t3_adr",   at(st_adr, 0), 32'd0);
        check_eq("t3_dat",   at(st_dat, 0), 32'd0);

        // 4: signed slt: -1 < 1
        prog = '{32'h2001ffff, 32'h20020001, 32'h0022182a, 32'hac030004};
        restart();
        run(6);
        check_eq("t4_count", st_adr.size(), 32'd1);
        check_eq("t4_adr",   at(st_adr, 0), 32'd4);
        check_eq("t4_dat",   at(st_dat, 0), 32'd1);

        // 5: beq taken, beq not taken, j, unknown funct as NOP
        prog = '{32'h20010003, 32'h20020003, 32'h10220002, 32'hac010008,
                 32'hac01000c, 32'h20030004, 32'h10230005, 32'hac030010,
                 32'h0800000b, 32'hac010014, 32'hac010018, 32'h20040009,
                 32'hac04001c, 32'h0082183f, 32'hac030020};
        restart();
        run(16);
        check_eq("t5_count", st_adr.size(), 32'd3);
        check_eq("t5_nt_adr",   at(st_adr, 0), 32'd16);
        check_eq("t5_nt_dat",   at(st_dat, 0), 32'd4);
        check_eq("t5_j_adr",    at(st_adr, 1), 32'd28);
        check_eq("t5_j_dat",    at(st_dat, 1), 32'd9);
        check_eq("t5_nop_adr",  at(st_adr, 2), 32'd32);
        check_eq("t5_nop_dat",  at(st_dat, 2), 32'd4);

        // 6: reset pulse after the first store restarts the program
        set_std();
        restart();
        run(13);
        check_eq("t6_pre_count", st_adr.size(), 32'd1);
        check_eq("t6_pre_adr",   at(st_adr, 0), 32'd80);
        reset = 1'b0;
        #1;
        check_eq("t6_rst_memwrite", {31'd0, bus.memwrite}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("t6_fetch0_adr", bus.dataadr, 32'd5);
        st_adr.delete();
        st_dat.delete();
        run(25);
        check_eq("t6_count", st_adr.size(), 32'd2);
        check_eq("t6_adr0",  at(st_adr, 0), 32'd80);
        check_eq("t6_dat0",  at(st_dat, 0), 32'd7);
        check_eq("t6_adr1",  at(st_adr, 1), 32'd84);
        check_eq("t6_dat1",  at(st_dat, 1), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
